// File: rtl/mtm_alu_serializer_pkg.sv
// mtm_alu_serializer_pkg: shared frame format and FSM encodings for the mtm_Alu serial link
package mtm_alu_serializer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        TYPE,
        PAYLOAD,
        STOP
    } state_t;

    localparam int FRAME_LEN = 11;
    localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);
    localparam logic TYPE_DATA = 1'b0;
    localparam logic TYPE_CTRL = 1'b1;

endpackage

// File: rtl/mtm_alu_serializer_frame_tx.sv
// mtm_alu_serializer_frame_tx: shifts one 11-bit frame {start, type, payload MSB first, stop}
module mtm_alu_serializer_frame_tx
    import mtm_alu_serializer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       frame_type,
    input  logic [7:0] payload,
    output logic       bit_out,
    output logic       done
);

    logic [10:0] shreg;
    logic [3:0]  cnt;
    logic        active;

    // load a fresh frame (takes priority over the stop bit of the previous one) or shift out the next bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            shreg  <= {1'b0, frame_type, payload, 1'b1};
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            shreg  <= {shreg[9:0], 1'b1};
            cnt    <= cnt == LAST_BIT ? '0 : cnt + 4'd1;
            active <= cnt != LAST_BIT;
        end
    end

    // the line idles high outside a frame; done marks the stop-bit cycle
    always_comb begin
        bit_out = active ? shreg[10] : 1'b1;
        done    = active && cnt == LAST_BIT;
    end

endmodule

// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: sends an ALU result as N_BYTES data frames plus a control frame, or a single error frame
module mtm_alu_serializer
    import mtm_alu_serializer_pkg::*;
#(
    parameter int N_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*N_BYTES-1:0]   C,
    input  logic [3:0]             flags,
    input  logic [2:0]             crc,
    input  logic                   valid,
    input  logic                   err_valid,
    input  logic [7:0]             err_frame,
    output logic                   sout,
    output logic                   busy
);

    localparam int FW = $clog2(N_BYTES + 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(N_BYTES);

    state_t               state, next_state;
    logic [2:0]           bit_cnt;
    logic [FW-1:0]        frame_cnt, next_frame;
    logic [8*N_BYTES-1:0] cap_c, shifted;
    logic [3:0]           cap_flags;
    logic [2:0]           cap_crc;
    logic                 accept, more, load, load_type, tx_bit, tx_done;
    logic [7:0]           load_payload;

    // request acceptance and selection of the next frame to hand to the shifter
    always_comb begin
        accept       = state == IDLE && (valid || err_valid);
        more         = frame_cnt != LAST_FRAME;
        next_frame   = frame_cnt + 1'b1;
        shifted      = cap_c << (8 * next_frame);
        load         = accept || (state == STOP && tx_done && more);
        load_type    = accept ? (err_valid ? TYPE_CTRL : TYPE_DATA)
                              : (next_frame == LAST_FRAME ? TYPE_CTRL : TYPE_DATA);
        load_payload = accept ? (err_valid ? err_frame : C[8*N_BYTES-1 -: 8])
                              : (next_frame == LAST_FRAME ? {1'b0, cap_flags, cap_crc}
                                                          : shifted[8*N_BYTES-1 -: 8]);
    end

    // frame sequencing: one pass through START..STOP per frame, back-to-back until the control frame is out
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? START : IDLE;
            START:   next_state = TYPE;
            TYPE:    next_state = PAYLOAD;
            PAYLOAD: next_state = bit_cnt == 3'd7 ? STOP : PAYLOAD;
            STOP:    next_state = tx_done ? (more ? START : IDLE) : STOP;
            default: next_state = IDLE;
        endcase
    end

    // state, counters and request capture; an error request jumps straight to the control frame index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            cap_c     <= '0;
            cap_flags <= '0;
            cap_crc   <= '0;
        end else begin
            state   <= next_state;
            bit_cnt <= state == PAYLOAD ? bit_cnt + 3'd1 : 3'd0;
            if (accept) begin
                cap_c     <= C;
                cap_flags <= flags;
                cap_crc   <= crc;
                frame_cnt <= err_valid ? LAST_FRAME : '0;
            end else if (state == STOP && next_state == START) begin
                frame_cnt <= next_frame;
            end
        end
    end

    mtm_alu_serializer_frame_tx u_tx (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .frame_type (load_type),
        .payload    (load_payload),
        .bit_out    (tx_bit),
        .done       (tx_done)
    );

    // line driven from the shifter only inside a frame, high otherwise so reset aborts cleanly
    always_comb begin
        busy = state != IDLE;
        sout = (state == START || state == TYPE || state == PAYLOAD) ? tx_bit : 1'b1;
    end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// tb_mtm_alu_serializer: directed scoreboard bench for the ALU result serializer
module tb_mtm_alu_serializer;

    logic        clk, rst, valid, err_valid, sout, busy;
    logic [31:0] C;
    logic [3:0]  flags;
    logic [2:0]  crc;
    logic [7:0]  err_frame;

    logic [10:0] exp_q[$];
    int          busy_q[$];
    int          checks = 0, errors = 0;
    int          nbits = 0, run = 0;
    logic [10:0] frm = '0;
    logic        final_req = 1'b0, final_done = 1'b0;

    mtm_alu_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .C         (C),
        .flags     (flags),
        .crc       (crc),
        .valid     (valid),
        .err_valid (err_valid),
        .err_frame (err_frame),
        .sout      (sout),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [10:0] fr(input logic t, input logic [7:0] p);
        return {1'b0, t, p, 1'b1};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_data(input logic [31:0] c, input logic [3:0] f, input logic [2:0] cr);
        for (int i = 0; i < 4; i++) exp_q.push_back(fr(1'b0, c[31-8*i -: 8]));
        exp_q.push_back(fr(1'b1, {1'b0, f, cr}));
        busy_q.push_back(55);
    endtask

    task automatic push_err(input logic [7:0] ef);
        exp_q.push_back(fr(1'b1, ef));
        busy_q.push_back(11);
    endtask

    task automatic req(input logic v, input logic e, input logic [31:0] c, input logic [3:0] f,
                       input logic [2:0] cr, input logic [7:0] ef);
        valid = v;
        err_valid = e;
        C = c;
        flags = f;
        crc = cr;
        err_frame = ef;
        @(posedge clk);
        #1;
        valid = 1'b0;
        err_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor: decode frames off the line, measure busy runs, compare against the scoreboard queues
    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_sout_busy", {30'd0, sout, busy}, 32'd2);
            nbits = 0;
            run = 0;
        end else begin
            if (nbits != 0 || !sout) begin
                frm = {frm[9:0], sout};
                nbits++;
                if (nbits == 11) begin
                    nbits = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", frm);
                    end else begin
                        chk("frame", {21'd0, frm}, {21'd0, exp_q.pop_front()});
                    end
                end
            end
            if (busy) begin
                run++;
                if (run == 300) begin
                    $display("FAIL busy_timeout: got busy high for %0d cycles expected at most 55", run);
                    $fatal(1, "busy stuck");
                end
            end else if (run != 0) begin
                if (busy_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_busy: got run %0d expected none", run);
                end else begin
                    chk("busy_len", run, busy_q.pop_front());
                end
                run = 0;
            end
        end
        if (final_req && !final_done) begin
            chk("frames_left", exp_q.size(), 0);
            chk("busy_left", busy_q.size(), 0);
            final_done = 1'b1;
        end
    end

    initial begin
        rst = 1'b0;
        valid = 1'b0;
        err_valid = 1'b0;
        C = '0;
        flags = '0;
        crc = '0;
        err_frame = '0;
        cycles(3);
        rst = 1'b1;

        push_data(32'h12345678, 4'b0000, 3'b101);
        req(1'b1, 1'b0, 32'h12345678, 4'b0000, 3'b101, 8'h00);
        cycles(60);

        push_err(8'hE0);
        req(1'b0, 1'b1, 32'h0, 4'h0, 3'h0, 8'hE0);
        cycles(15);

        push_err(8'h98);
        req(1'b1, 1'b1, 32'hDEADBEEF, 4'b1001, 3'b110, 8'h98);
        cycles(15);

        push_data(32'hA5C31E0F, 4'b1010, 3'b011);
        req(1'b1, 1'b0, 32'hA5C31E0F, 4'b1010, 3'b011, 8'h00);
        cycles(19);
        req(1'b1, 1'b1, 32'h11111111, 4'b0101, 3'b001, 8'h42);
        cycles(35);
        push_data(32'h0BADCAFE, 4'b0011, 3'b100);
        req(1'b1, 1'b0, 32'h0BADCAFE, 4'b0011, 3'b100, 8'h00);
        cycles(60);

        push_data(32'hCAFEF00D, 4'b0110, 3'b010);
        req(1'b1, 1'b0, 32'hCAFEF00D, 4'b0110, 3'b010, 8'h00);
        cycles(26);
        rst = 1'b0;
        exp_q.delete();
        busy_q.delete();
        exp_q.push_back(fr(1'b0, 8'hCA));
        exp_q.push_back(fr(1'b0, 8'hFE));
        exp_q.delete();
        cycles(2);
        rst = 1'b1;
        push_data(32'h89ABCDEF, 4'b1100, 3'b001);
        req(1'b1, 1'b0, 32'h89ABCDEF, 4'b1100, 3'b001, 8'h00);
        cycles(60);

        push_data(32'hFFFFFFFF, 4'b1111, 3'b111);
        req(1'b1, 1'b0, 32'hFFFFFFFF, 4'b1111, 3'b111, 8'h00);
        cycles(60);

        final_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mtm_alu_serializer.md
MTM_ALU_SERIALIZER -- requirements
Module: mtm_Alu_serializer

Interface
REQ-001 SHALL have parameter N_BYTES, default 4: number of data frames per result; the result width is 8*N_BYTES.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port C, input, 8*N_BYTES bits: ALU result word.
REQ-005 SHALL have port flags, input, 4 bits: ALU status flags {carry, overflow, zero, negative}.
REQ-006 SHALL have port crc, input, 3 bits: result CRC computed upstream.
REQ-007 SHALL have port valid, input, 1 bit: C/flags/crc valid this cycle.
REQ-008 SHALL have port err_valid, input, 1 bit: error response requested this cycle.
REQ-009 SHALL have port err_frame, input, 8 bits: control byte for the error response.
REQ-010 SHALL have port sout, output, 1 bit: serial line; idles high.
REQ-011 SHALL have port busy, output, 1 bit: transmission in progress; inputs are ignored while high.

Function
REQ-012 Frame SHALL be 11 bits, one bit per clk, in order: start 0, type bit (0 data / 1 control), 8 payload bits MSB first, stop 1.
REQ-013 A request SHALL be accepted on the rising edge where (valid|err_valid) && !busy; C/flags/crc/err_frame SHALL be captured into internal registers at that edge.
REQ-014 The start bit of the first frame SHALL appear on sout in the cycle after acceptance (latency 1).
REQ-015 Data response SHALL be N_BYTES data frames (C[8N-1:8N-8] first, C[7:0] last), then one control frame with payload {1'b0, flags, crc}.
REQ-016 Error response SHALL be one control frame with payload err_frame.
REQ-017 If valid and err_valid are both high at acceptance, the error response SHALL be sent and the data request discarded.
REQ-018 Frames SHALL be sent back-to-back, with no idle bits between the stop bit and the next start bit.
REQ-019 busy SHALL be high from the cycle after acceptance through the last stop-bit cycle inclusive: 11*(N_BYTES+1) cycles for data, 11 for error.
REQ-020 A new request SHALL be acceptable in the first cycle busy is low. A request held while busy is high SHALL be dropped, not queued.
REQ-021 FSM states SHALL be IDLE, START, TYPE, PAYLOAD, STOP. Transitions:
  - IDLE->START on accept.
  - START->TYPE->PAYLOAD.
  - PAYLOAD->STOP after 8 bits.
  - STOP->START if frames remain, else STOP->IDLE.
REQ-022 The bit counter SHALL be 3 bits and wrap 7->0 on leaving PAYLOAD. The frame counter SHALL count 0..N_BYTES, with frame N_BYTES being the control frame.
REQ-023 sout SHALL be 1 in IDLE and STOP, 0 in START, and the type bit in TYPE.

Reset
REQ-024 While rst is low, sout SHALL be 1, busy 0, FSM IDLE, and counters and captured registers 0, independent of clk.
REQ-025 Reset asserted mid-frame SHALL abort the transmission immediately (sout high, no partial stop bit required).
REQ-026 After rst deasserts, the first request SHALL be acceptable on the first rising edge.

Structure
REQ-027 FSM state encodings, frame length (11), and type-bit values SHALL live in the shared mtm_Alu definitions include, also used by mtm_Alu_deserializer.
REQ-028 The block SHALL be one FSM plus one sub-module, mtm_Alu_frame_tx:
  - loads {type, payload} and shifts one 11-bit frame;
  - asserts done on the stop bit.

Verification
REQ-029 Data response: C=32'h12345678, flags=4'b0000, crc=3'b101, valid pulse -> frames 0x12, 0x34, 0x56, 0x78 with type 0, then control 0x05 with type 1. First 11 sout bits: 0,0,0,0,0,1,0,0,1,0,1. busy high for 55 cycles.
REQ-030 Error response: err_valid with err_frame=8'hE0 -> single frame 0,1,1,1,1,0,0,0,0,0,1. busy high for 11 cycles.
REQ-031 Simultaneous requests: valid and err_valid high together with err_frame=8'h98 -> only the error frame is sent; C is never transmitted.
REQ-032 Drop while busy: valid pulsed at cycle 20 of a data response -> no extra frames. A new valid in the first cycle busy is low -> start bit in the next cycle, no gap.
REQ-033 Reset mid-operation: rst low during the third payload bit of frame 2 -> sout=1 and busy=0 in the same cycle. The next request after release is transmitted correctly from frame 0.
REQ-034 All-ones data: C=32'hFFFFFFFF, flags=4'b1111, crc=3'b111 -> each data frame is 0,0,1x8,1 and the control payload is 0x7F.
